// File: rtl/i_ref_setup_pkg.sv
// Shared types and constants for the I_REF setup SAR sequencer.
// Optional feature macro: I_REF_SETUP_AVG_EN (3-sample majority decision per bit).
package i_ref_setup_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } i_ref_setup_state_t;

  // Number of comparator samples voted on per bit when averaging is enabled.
  localparam int unsigned MAJ_SAMPLES = 3;

  // Majority of three single-bit votes.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i_ref_setup_voter.sv
// 3-sample majority voter: keeps the two previous comparator samples and
// votes them together with the current one. Used only with I_REF_SETUP_AVG_EN.
module i_ref_setup_voter
  import i_ref_setup_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic din,
  output logic vote
);

  logic [MAJ_SAMPLES-2:0] hist_q, hist_d;

  // Shift in a new sample on every enabled cycle.
  always_comb begin
    hist_d = hist_q;
    if (shift_en) hist_d = {hist_q[MAJ_SAMPLES-3:0], din};
  end

  // History register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= hist_d;
  end

  // The vote includes the current sample so the decision lands on the third edge.
  assign vote = majority3({hist_q, din});

endmodule

// File: rtl/i_ref_setup_ctrl.sv
// SAR sequencer for the I_REF setup code. Searches MSB->LSB using a 1-bit
// comparator, then raises completed to switch i_ref_mux to the operational i_ref.
// Optional feature macro: I_REF_SETUP_AVG_EN (3-cycle SAMPLE with majority vote).
module i_ref_setup_ctrl
  import i_ref_setup_pkg::*;
#(
  parameter int unsigned BUS_WIDTH     = 10,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 comp_in,
  output logic [BUS_WIDTH-1:0] i_ref_setup,
  output logic                 completed,
  output logic                 busy
);

  localparam int unsigned BIT_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  i_ref_setup_state_t   state_q, state_d;
  logic [BUS_WIDTH-1:0] code_q, code_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 completed_q, completed_d;
  logic                 busy_q, busy_d;
  logic                 decide;
  logic                 last_sample;

`ifdef I_REF_SETUP_AVG_EN
  logic [1:0] smp_q, smp_d;
  logic       vote;

  i_ref_setup_voter u_voter (
    .clk      (clk),
    .rst      (rst),
    .shift_en (state_q == SAMPLE),
    .din      (comp_in),
    .vote     (vote)
  );

  assign decide      = vote;
  assign last_sample = (smp_q == 2'(MAJ_SAMPLES - 1));
`else
  assign decide      = comp_in;
  assign last_sample = 1'b1;
`endif

  // Next-state, code, counter and output computation.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    code_d      = code_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    completed_d = completed_q;
    busy_d      = busy_q;
`ifdef I_REF_SETUP_AVG_EN
    smp_d       = smp_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          code_d                = '0;
          code_d[BUS_WIDTH-1]   = 1'b1;
          bit_d                 = BIT_W'(BUS_WIDTH - 1);
          cnt_d                 = '0;
          completed_d           = 1'b0;
          busy_d                = 1'b1;
          state_d               = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
`ifdef I_REF_SETUP_AVG_EN
          smp_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        if (last_sample) begin
          // Generated current above target: this bit is too large, drop it.
          if (decide) code_d[bit_q] = 1'b0;
          if (bit_q != '0) begin
            code_d[bit_q - 1'b1] = 1'b1;
            bit_d                = bit_q - 1'b1;
            cnt_d                = '0;
            state_d              = SETTLE;
          end else begin
            completed_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = DONE;
          end
        end
`ifdef I_REF_SETUP_AVG_EN
        else begin
          smp_d = smp_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset parks the code at max for safety.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= '1;
      bit_q       <= '0;
      cnt_q       <= '0;
      completed_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef I_REF_SETUP_AVG_EN
      smp_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      code_q      <= code_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      completed_q <= completed_d;
      busy_q      <= busy_d;
`ifdef I_REF_SETUP_AVG_EN
      smp_q       <= smp_d;
`endif
    end
  end

  assign i_ref_setup = code_q;
  assign completed   = completed_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i_ref_setup_ctrl.sv
// Self-checking bench for i_ref_setup_ctrl: table of search targets plus random
// targets, checked against a threshold comparator model; hand-written reset cases.
// Build with I_REF_SETUP_AVG_EN defined to exercise the majority-vote variant.
module tb_i_ref_setup_ctrl;

  localparam int BW = 10;
  localparam int SC = 8;
`ifdef I_REF_SETUP_AVG_EN
  localparam int SPB = 3;
`else
  localparam int SPB = 1;
`endif
  localparam int PERIOD  = SC + SPB;
  localparam int EXP_LAT = BW * PERIOD;
  localparam int MAX_CODE = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          comp_in;
  logic [BW-1:0] i_ref_setup;
  logic          completed;
  logic          busy;

  logic [BW-1:0] target = '0;
  logic          glitch = 1'b0;
  logic [BW-1:0] i_ref_op = 10'h2A5;
  logic [BW-1:0] mux_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Analog comparator model: generated current above target when code > target.
  assign comp_in = (i_ref_setup > target) ^ glitch;
  // Downstream i_ref_mux model.
  assign mux_out = completed ? i_ref_op : i_ref_setup;

  i_ref_setup_ctrl #(.BUS_WIDTH(BW), .SETTLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .comp_in     (comp_in),
    .i_ref_setup (i_ref_setup),
    .completed   (completed),
    .busy        (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the largest code the comparator reports as not above target.
  function automatic int ref_result(input int tgt);
    int res = -1;
    for (int c = 0; c <= MAX_CODE; c++)
      if (!(c > tgt)) res = c;
    return res;
  endfunction

  typedef struct {
    int tgt;
    int start_at;   // edge index after accept at which a stray start pulses (0 = none)
  } vec_t;

  // One full search: accept, run to completion, check latency and result.
  task automatic run_search(input int tgt, input int start_at, input bit glitch_en,
                            input string tag);
    int done_at = -1;
    int gidx = 0;
    bit busy_ok = 1'b1;
    int exp_code = ref_result(tgt);
    target = BW'(tgt);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " accept busy"}, int'(busy), 1);
    check({tag, " accept completed"}, int'(completed), 0);
    check({tag, " accept code"}, int'(i_ref_setup), 1 << (BW - 1));
    for (int n = 1; n <= 4 * EXP_LAT; n++) begin
      @(negedge clk);
      start = (n == start_at);
      if ((n - 1) % PERIOD == SC) gidx = $urandom_range(SPB - 1, 0);
      glitch = glitch_en && ((n - 1) % PERIOD == SC + gidx);
      @(posedge clk);
      #1;
      if (completed === 1'b1) begin
        done_at = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    @(negedge clk);
    start  = 1'b0;
    glitch = 1'b0;
    check({tag, " busy during search"}, int'(busy_ok), 1);
    check({tag, " latency"}, done_at, EXP_LAT);
    check({tag, " result"}, int'(i_ref_setup), exp_code);
    check({tag, " busy at done"}, int'(busy), 0);
    check({tag, " mux selects i_ref"}, int'(mux_out), int'(i_ref_op));
  endtask

  initial begin
    vec_t vecs[$];
    bit   glitch_en;
`ifdef I_REF_SETUP_AVG_EN
    glitch_en = 1'b1;
`else
    glitch_en = 1'b0;
`endif
    vecs.push_back('{341, 0});
    vecs.push_back('{0, 0});
    vecs.push_back('{MAX_CODE, 0});
    vecs.push_back('{341, 20});
    vecs.push_back('{600, 0});
    vecs.push_back('{1, 0});
    vecs.push_back('{512, 0});
    vecs.push_back('{511, 0});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{int'($urandom_range(MAX_CODE, 0)), 0});

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("async reset code", int'(i_ref_setup), MAX_CODE);
    check("async reset completed", int'(completed), 0);
    check("async reset busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post reset hold code", int'(i_ref_setup), MAX_CODE);
    check("post reset hold busy", int'(busy), 0);
    check("post reset hold completed", int'(completed), 0);

    // Table of searches; consecutive runs also exercise restart from DONE.
    foreach (vecs[i])
      run_search(vecs[i].tgt, vecs[i].start_at, glitch_en,
                 $sformatf("vec%0d t=%0d", i, vecs[i].tgt));

    // Reset in the middle of a search.
    target = BW'(777);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midsearch reset code", int'(i_ref_setup), MAX_CODE);
    check("midsearch reset busy", int'(busy), 0);
    check("midsearch reset completed", int'(completed), 0);
    @(negedge clk) rst = 1'b0;
    repeat (3 * PERIOD) @(posedge clk);
    #1;
    check("idle after reset code", int'(i_ref_setup), MAX_CODE);
    check("idle after reset busy", int'(busy), 0);
    check("idle after reset completed", int'(completed), 0);

    // A fresh start after mid-search reset still converges.
    run_search(600, 0, glitch_en, "after reset t=600");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
